// File: rtl/angle_ctrl_pkg.sv
// angle_ctrl_pkg: state encoding, angle constants and shortest-path error helper
package angle_ctrl_pkg;
  localparam int ANGLE_W = 12;
  localparam int FULL_TURN = 4096;
  localparam int HALF_TURN = 2048;
  // bit 2 marks the active states so busy/angle_done come straight off a flop
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    DONE    = 3'b001,
    FAULT   = 3'b010,
    MEASURE = 3'b100,
    ACCEL   = 3'b101,
    CRUISE  = 3'b110,
    DECEL   = 3'b111
  } state_t;
  typedef struct packed {
    logic dir;
    logic [ANGLE_W-1:0] mag;
  } err_t;
  function automatic err_t angle_err(input logic [ANGLE_W-1:0] tgt, input logic [ANGLE_W-1:0] ang);
    logic [ANGLE_W-1:0] diff;
    err_t e;
    diff = tgt - ang;
    e.dir = diff <= ANGLE_W'(HALF_TURN);
    e.mag = e.dir ? diff : ANGLE_W'(FULL_TURN - int'(diff));
    return e;
  endfunction
  function automatic logic is_motion(input state_t s);
    return s == ACCEL || s == CRUISE || s == DECEL;
  endfunction
endpackage

// File: rtl/angle_ctrl_pwm_gen.sv
// pwm_gen: free-running 8-bit counter compared against duty, registered output
module pwm_gen (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] duty,
  output logic       pwm
);
  logic [7:0] cnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + 8'd1;
      pwm <= en && (cnt < duty);
    end
  end
endmodule

// File: rtl/angle_ctrl.sv
// angle_ctrl: closed-loop motor positioner driven by a filtered AS5600 angle
module angle_ctrl
  import angle_ctrl_pkg::*;
#(
  parameter logic [11:0] TOLERANCE  = 12'd8,
  parameter logic [11:0] DECEL_ZONE = 12'd256,
  parameter logic [7:0]  MIN_DUTY   = 8'd40,
  parameter logic [7:0]  MAX_DUTY   = 8'd200,
  parameter logic [15:0] RAMP_DIV   = 16'd1000,
  parameter logic [15:0] SETTLE_CYC = 16'd4000,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_req,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic               abort,
  input  logic [ANGLE_W-1:0] raw_angle,
  output logic               angle_done,
  output logic               pwm,
  output logic               dir,
  output logic               busy,
  output logic               stall_err
);
  state_t state;
  logic [ANGLE_W-1:0] raw_q, angle, tgt, mag;
  logic dir_c;
  logic [7:0] duty;
  logic [15:0] set_cnt, ramp_cnt;
  logic [23:0] mot_cnt;
  logic ramp_tick, timeout_hit, in_tol, in_decel;
  assign {dir_c, mag} = angle_err(tgt, angle);
  assign ramp_tick = ramp_cnt == RAMP_DIV - 16'd1;
  assign timeout_hit = mot_cnt == TIMEOUT - 24'd1;
  assign in_tol = mag <= TOLERANCE;
  assign in_decel = mag <= DECEL_ZONE;
  assign busy = state[2];
  assign angle_done = ~state[2];
  // the reader shifts bits in serially, so only a value seen twice in a row is trusted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= '0;
      angle <= '0;
    end else begin
      raw_q <= raw_angle;
      if (raw_angle == raw_q) angle <= raw_angle;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt <= '0;
      duty <= '0;
      dir <= 1'b0;
      stall_err <= 1'b0;
      set_cnt <= '0;
      ramp_cnt <= '0;
      mot_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE, FAULT: if (start_req) begin
          state <= MEASURE;
          tgt <= target_angle;
          stall_err <= 1'b0;
          set_cnt <= '0;
          ramp_cnt <= '0;
          mot_cnt <= '0;
        end
        MEASURE: begin
          dir <= dir_c;
          if (set_cnt == SETTLE_CYC - 16'd1) begin
            state <= in_tol ? DONE : ACCEL;
            duty <= MIN_DUTY;
          end else set_cnt <= set_cnt + 16'd1;
        end
        default: begin
          mot_cnt <= mot_cnt + 24'd1;
          ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 16'd1;
          if (in_tol) state <= DONE;
          else if (timeout_hit) begin
            state <= FAULT;
            stall_err <= 1'b1;
          end else if (in_decel) state <= DECEL;
          else if (state == ACCEL && duty >= MAX_DUTY) state <= CRUISE;
          if (ramp_tick && state == ACCEL && duty < MAX_DUTY) duty <= duty + 8'd1;
          if (ramp_tick && state == DECEL && duty > MIN_DUTY) duty <= duty - 8'd1;
        end
      endcase
    end
  end
  pwm_gen u_pwm (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (is_motion(state) && !abort),
    .duty   (duty),
    .pwm    (pwm)
  );
endmodule

// File: tb/tb_angle_ctrl.sv
// tb_angle_ctrl: directed stimulus with a queue-based scoreboard on angle_done rising
`timescale 1ns/1ps
module tb_angle_ctrl;
  import angle_ctrl_pkg::*;
  localparam int SETTLE = 200;
  localparam int RAMP = 20;
  localparam int TMO = 5000;
  typedef struct {
    string  name;
    state_t st;
    int     dir;
    int     stall;
    int     low;
    int     pwm;
  } exp_t;
  logic clock = 1'b0, reset_n = 1'b0, start_req = 1'b0, abort = 1'b0;
  logic [11:0] target_angle = '0, raw_angle = '0;
  logic angle_done, pwm, dir, busy, stall_err;
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t cur;
  int low_cnt = 0, cruise_cycles = 0, cruise_snap = 0, done_raw = 0;
  logic pwm_seen = 1'b0, prev_done = 1'b1;

  angle_ctrl #(
    .SETTLE_CYC(16'(SETTLE)),
    .RAMP_DIV  (16'(RAMP)),
    .TIMEOUT   (24'(TMO))
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_req   (start_req),
    .target_angle(target_angle),
    .abort       (abort),
    .raw_angle   (raw_angle),
    .angle_done  (angle_done),
    .pwm         (pwm),
    .dir         (dir),
    .busy        (busy),
    .stall_err   (stall_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input state_t s, input int max, input string name);
    int i;
    i = 0;
    while (dut.state != s && i < max) begin
      tick(1);
      i++;
    end
    chk({name, "_reached"}, int'(dut.state == s), 1);
  endtask

  task automatic set_raw(input logic [11:0] r);
    raw_angle = r;
    tick(3);
  endtask

  task automatic start(input logic [11:0] t, input exp_t e);
    sb.push_back(e);
    target_angle = t;
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // monitor: every rising angle_done retires one expected transaction
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      low_cnt = 0;
      pwm_seen = 1'b0;
      prev_done = 1'b1;
    end else begin
      if (angle_done && !prev_done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          cur = sb.pop_front();
          chk({cur.name, "_state"}, int'(dut.state), int'(cur.st));
          chk({cur.name, "_dir"}, int'(dir), cur.dir);
          chk({cur.name, "_stall"}, int'(stall_err), cur.stall);
          if (cur.low >= 0) chk({cur.name, "_low_cycles"}, low_cnt, cur.low);
          if (cur.pwm >= 0) chk({cur.name, "_pwm_seen"}, int'(pwm_seen), cur.pwm);
        end
        low_cnt = 0;
        pwm_seen = 1'b0;
      end
      if (!angle_done) begin
        low_cnt++;
        pwm_seen = pwm_seen | pwm;
      end
      prev_done = angle_done;
    end
  end

  initial forever begin
    @(negedge clock);
    if (dut.state == CRUISE) cruise_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall_err), 0);
    chk("rst_angle_done", int'(angle_done), 1);
    chk("rst_state", int'(dut.state), int'(IDLE));
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      raw_angle = i[0] ? 12'h555 : 12'hAAA;
      tick(1);
    end
    chk("filter_glitch", int'(dut.angle), 0);
    raw_angle = 12'd300;
    tick(1);
    chk("filter_early", int'(dut.angle), 0);
    tick(1);
    chk("filter_load", int'(dut.angle), 300);

    set_raw(12'd4000);
    cruise_snap = cruise_cycles;
    start(12'd100, exp_t'{"near", DONE, 1, 0, -1, -1});
    tick(2);
    chk("near_mag", int'(dut.mag), 196);
    wait_state(ACCEL, SETTLE + 5, "near_accel");
    chk("near_dir", int'(dir), 1);
    tick(1);
    chk("near_decel", int'(dut.state), int'(DECEL));
    done_raw = -1;
    for (int k = 1; k <= 40 && done_raw < 0; k++) begin
      raw_angle = 12'((4000 + 10 * k) % 4096);
      for (int c = 0; c < 4 && done_raw < 0; c++) begin
        tick(1);
        if (dut.state == DONE) done_raw = int'(raw_angle);
      end
    end
    chk("near_done_raw", done_raw, 94);
    chk("near_no_cruise", cruise_cycles - cruise_snap, 0);

    set_raw(12'd2048);
    start(12'd0, exp_t'{"dir_half", IDLE, 1, 0, -1, -1});
    wait_state(ACCEL, SETTLE + 5, "dir_half_accel");
    pulse_abort();
    set_raw(12'd2047);
    start(12'd0, exp_t'{"dir_past", IDLE, 0, 0, -1, -1});
    wait_state(ACCEL, SETTLE + 5, "dir_past_accel");
    pulse_abort();

    set_raw(12'd1005);
    start(12'd1000, exp_t'{"tol", DONE, 0, 0, SETTLE, 0});
    wait_state(DONE, SETTLE + 5, "tol_done");

    set_raw(12'd0);
    start(12'd2000, exp_t'{"stall", FAULT, 1, 1, SETTLE + TMO, -1});
    wait_state(FAULT, SETTLE + TMO + 10, "stall_fault");
    chk("stall_flag", int'(stall_err), 1);

    start(12'd2000, exp_t'{"abort", IDLE, 1, 0, -1, -1});
    chk("restart_clears_stall", int'(stall_err), 0);
    wait_state(CRUISE, SETTLE + 3400, "abort_cruise");
    chk("cruise_duty", int'(dut.duty), 200);
    abort = 1'b1;
    start_req = 1'b1;
    target_angle = 12'd50;
    tick(1);
    abort = 1'b0;
    start_req = 1'b0;
    chk("abort_pwm", int'(pwm), 0);
    chk("abort_angle_done", int'(angle_done), 1);
    chk("abort_state", int'(dut.state), int'(IDLE));
    chk("abort_tgt_kept", int'(dut.tgt), 2000);

    target_angle = 12'd2000;
    start_req = 1'b1;
    tick(1);
    start_req = 1'b0;
    for (int i = 0; i < SETTLE + 600 && !pwm; i++) tick(1);
    chk("rst_mid_pwm_high", int'(pwm), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_pwm", int'(pwm), 0);
    chk("rst_async_done", int'(angle_done), 1);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/angle_ctrl.md
ANGLE_CTRL -- requirements
Module: angle_ctrl

Interface
REQ-001 Parameter: TOLERANCE, 12'd8, done window in encoder counts.
REQ-002 Parameter: DECEL_ZONE, 12'd256, error magnitude at which deceleration begins.
REQ-003 Parameter: MIN_DUTY, 8'd40, starting and floor duty.
REQ-004 Parameter: MAX_DUTY, 8'd200, cruise duty ceiling.
REQ-005 Parameter: RAMP_DIV, 16'd1000, clocks per one-step duty change.
REQ-006 Parameter: SETTLE_CYC, 16'd4000, clocks held in MEASURE before the first evaluation.
REQ-007 Parameter: TIMEOUT, 24'hFFFFFF, motion-state clock limit before a fault.
REQ-008 Port: clock  input  1  main clock.
REQ-009 Port: reset_n  input  1  asynchronous active-low reset.
REQ-010 Port: start_req  input  1  one-cycle request to move to target_angle.
REQ-011 Port: target_angle  input  12  requested angle, sampled when start_req is accepted.
REQ-012 Port: abort  input  1  immediate stop request.
REQ-013 Port: raw_angle  input  12  AS5600 raw angle from the I2C reader.
REQ-014 Port: angle_done  output  1  high means no encoder reads are needed; it gates the I2C reader.
REQ-015 Port: pwm  output  1  motor PWM.
REQ-016 Port: dir  output  1  1 = increasing angle, 0 = decreasing angle.
REQ-017 Port: busy  output  1  high in MEASURE, ACCEL, CRUISE and DECEL.
REQ-018 Port: stall_err  output  1  sticky timeout flag.

Function
REQ-019 The angle register SHALL load raw_angle only when raw_angle equals its value on the previous clock, filtering bit-serial update glitches.
REQ-020 Error SHALL be computed as diff = (tgt - angle) mod 4096; if diff <= 2048 then dir = 1 and mag = diff, else dir = 0 and mag = 4096 - diff.
REQ-021 FSM states SHALL be IDLE, MEASURE, ACCEL, CRUISE, DECEL, DONE and FAULT.
REQ-022 IDLE, DONE or FAULT with start_req SHALL latch target_angle into tgt, clear stall_err, clear the counters, and enter MEASURE.
REQ-023 MEASURE SHALL hold angle_done = 0 for SETTLE_CYC clocks, then go to DONE if mag <= TOLERANCE, else to ACCEL with duty = MIN_DUTY.
REQ-024 ACCEL SHALL raise duty by 1 every RAMP_DIV clocks, enter CRUISE when duty reaches MAX_DUTY, and enter DECEL when mag <= DECEL_ZONE (DECEL has priority).
REQ-025 CRUISE SHALL enter DECEL when mag <= DECEL_ZONE.
REQ-026 DECEL SHALL lower duty by 1 every RAMP_DIV clocks, never below MIN_DUTY.
REQ-027 From ACCEL, CRUISE or DECEL, mag <= TOLERANCE SHALL take the FSM to DONE, and this check SHALL have priority over every other motion transition.
REQ-028 A motion clock counter SHALL run in ACCEL, CRUISE and DECEL; reaching TIMEOUT SHALL set stall_err and enter FAULT.
REQ-029 abort SHALL force IDLE from any state on the next clock, with pwm = 0 on that same clock; abort SHALL take priority over start_req.
REQ-030 start_req outside IDLE, DONE and FAULT SHALL be ignored.
REQ-031 angle_done SHALL be 0 in MEASURE, ACCEL, CRUISE and DECEL, and 1 in all other states.
REQ-032 The PWM SHALL use an 8-bit free-running counter; pwm is registered and equals (cnt < duty) only in ACCEL, CRUISE and DECEL, otherwise 0.
REQ-033 duty = 0 SHALL give a constant-low pwm.
REQ-034 Duty arithmetic SHALL saturate and never wrap.
REQ-035 dir SHALL update only in MEASURE and at entry to ACCEL, and SHALL be held constant during motion.

Reset
REQ-036 Reset SHALL put the FSM in IDLE and set duty, all counters, tgt and the angle registers to 0.
REQ-037 Output reset values SHALL be: pwm = 0, dir = 0, busy = 0, stall_err = 0, angle_done = 1.
REQ-038 Reset asserted mid-motion SHALL drop pwm asynchronously.

Structure
REQ-039 Package angle_ctrl_pkg SHALL hold the FSM state encoding, ANGLE_W = 12, FULL_TURN = 4096 and HALF_TURN = 2048.
REQ-040 Sub-module pwm_gen (counter plus compare, with duty and enable inputs) SHALL be instantiated once.

Verification
REQ-041 Bench SHALL check: tgt = 100, raw = 4000 -> dir = 1, mag = 196, FSM skips CRUISE (ACCEL then DECEL), and reaches DONE at raw = 94..106.
REQ-042 Bench SHALL check: tgt = 0, raw = 2048 -> dir = 1; tgt = 0, raw = 2047 -> dir = 0.
REQ-043 Bench SHALL check: start_req with raw = tgt + 5 -> MEASURE then DONE, pwm never high, angle_done low for exactly SETTLE_CYC clocks.
REQ-044 Bench SHALL check: raw frozen, TIMEOUT reduced to 5000 -> stall_err = 1 and FAULT after 5000 motion clocks; the next start_req clears stall_err.
REQ-045 Bench SHALL check: abort during CRUISE at duty 200 -> next clock IDLE, pwm = 0, angle_done = 1; a simultaneous start_req is ignored.
REQ-046 Bench SHALL check: raw_angle toggling every clock -> the angle register does not update; a stable value loads 1 clock later.
